alu_operand_stage: RTL and testbench

- Operand-fetch stage feeding the 16-bit ALU: 8-entry general register file (2 read, 1 write) plus one pipeline register that presents in1/in2/opcode to the ALU.
- Also holds the S/Z/C/V condition-flag register written from ALU flag outputs.
- Valid/ready handshake upstream (decode) and downstream (execute).
- Same-cycle write-back forwarding so a register written this cycle is read with its new value.

---
 rtl/alu_operand_stage.sv | 117 +++++++++++
 tb/tb_alu_operand_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// Purpose : operand-fetch stage for the 16-bit ALU. It holds an 8-entry
//           register file (2 read ports, 1 write port), one operand pipeline
//           register and the S/Z/C/V condition-flag register.
// Latency : 1 cycle from id accept to ex_valid.
// Backpressure: id_ready = !ex_valid || ex_ready. A stalled operation holds
//           every ex_* output stable. Write-back and flag updates never stall.
//
// Ports:
//   clk, rst                     clock; synchronous active-high reset
//   id_valid/id_ready            decode handshake
//   id_ra, id_rb, id_imm,        source registers, immediate, operand-2 select
//   id_use_imm, id_opcode        and opcode, which passes through unchanged
//   ex_valid/ex_ready            execute handshake
//   ex_in1, ex_in2, ex_opcode    registered operation presented to the ALU
//   wb_en, wb_addr, wb_data      register-file write port (write-first)
//   flag_we, alu_s/z/c/v, flags  condition-flag latch, flags = {S,Z,C,V}
//
// Build option: define OPFETCH_R0_ZERO_EN to hardwire R0 to zero.

module alu_operand_stage #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [ADDR_W-1:0] id_ra,
  input  logic [ADDR_W-1:0] id_rb,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [3:0]        id_opcode,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_in1,
  output logic [DATA_W-1:0] ex_in2,
  output logic [3:0]        ex_opcode,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flag_we,
  input  logic              alu_s,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v,
  output logic [3:0]        flags
);

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              fire;
  logic              wr_ok;

  assign id_ready = !ex_valid || ex_ready;
  assign fire     = id_valid && id_ready;

`ifdef OPFETCH_R0_ZERO_EN
  // R0 reads as constant zero, so any write aimed at it is dropped.
  assign wr_ok = wb_en && (wb_addr != '0);
`else
  assign wr_ok = wb_en;
`endif

  // Write-first read: a register being written this cycle is returned with
  // its new value. This lets decode issue a dependent instruction right
  // behind the producing write-back.
  always_comb begin
    rd_a = regs[id_ra];
    rd_b = regs[id_rb];
    if (wr_ok && wb_addr == id_ra) rd_a = wb_data;
    if (wr_ok && wb_addr == id_rb) rd_b = wb_data;
`ifdef OPFETCH_R0_ZERO_EN
    if (id_ra == '0) rd_a = '0;
    if (id_rb == '0) rd_b = '0;
`endif
  end

  // Register file
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Operand pipeline register: EMPTY when ex_valid = 0, FULL when ex_valid = 1.
  // When the stage drains, the data fields keep their last values; only
  // ex_valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_in1    <= '0;
      ex_in2    <= '0;
      ex_opcode <= '0;
    end else if (fire) begin
      ex_valid  <= 1'b1;
      ex_in1    <= rd_a;
      ex_in2    <= id_use_imm ? id_imm : rd_b;
      ex_opcode <= id_opcode;
    end else if (ex_ready) begin
      ex_valid  <= 1'b0;
    end
  end

  // Condition flags. ALU flag outputs are not forwarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= 4'b0000;
    end else if (flag_we) begin
      flags <= {alu_s, alu_z, alu_c, alu_v};
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Purpose : directed self-checking bench for alu_operand_stage.
// Latency : inputs change 1 ns after a rising edge; outputs are checked 1 ns
//           after the following edge.
// Backpressure: ex_ready is driven directly to produce stall cycles.

module tb_alu_operand_stage;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

`ifdef OPFETCH_R0_ZERO_EN
    localparam logic [15:0] R0_STORED = 16'h0000;
    localparam logic [15:0] R0_FWD    = 16'h0000;
`else
    localparam logic [15:0] R0_STORED = 16'hFFFF;
    localparam logic [15:0] R0_FWD    = 16'h5555;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic              id_ready;
    logic [ADDR_W-1:0] id_ra;
    logic [ADDR_W-1:0] id_rb;
    logic [DATA_W-1:0] id_imm;
    logic              id_use_imm;
    logic [3:0]        id_opcode;
    logic              ex_valid;
    logic              ex_ready;
    logic [DATA_W-1:0] ex_in1;
    logic [DATA_W-1:0] ex_in2;
    logic [3:0]        ex_opcode;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              flag_we;
    logic              alu_s;
    logic              alu_z;
    logic              alu_c;
    logic              alu_v;
    logic [3:0]        flags;

    int compared   = 0;
    int mismatched = 0;
    bit done       = 1'b0;

    alu_operand_stage #(.DATA_W(DATA_W), .NREG(8), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_ra(id_ra), .id_rb(id_rb), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_opcode(id_opcode),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_opcode(ex_opcode),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flag_we(flag_we), .alu_s(alu_s), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] ra, input logic [2:0] rb,
                         input logic use_imm, input logic [15:0] imm,
                         input logic [3:0] opc);
        id_valid   = 1'b1;
        id_ra      = ra;
        id_rb      = rb;
        id_use_imm = use_imm;
        id_imm     = imm;
        id_opcode  = opc;
    endtask

    task automatic wb(input logic en, input logic [2:0] a, input logic [15:0] d);
        wb_en   = en;
        wb_addr = a;
        wb_data = d;
    endtask

    initial begin
        #100000;
        if (!done) begin
            mismatched++;
            $error("FAIL timeout: wait expired before the test sequence completed");
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
            $finish;
        end
    end

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_ra = '0; id_rb = '0; id_imm = '0;
        id_use_imm = 1'b0; id_opcode = '0; ex_ready = 1'b1;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        flag_we = 1'b0; alu_s = 1'b0; alu_z = 1'b0; alu_c = 1'b0; alu_v = 1'b0;
        step(); step();
        rst = 1'b0;
        step();

        chk("rst_ex_valid", ex_valid, 1'b0);
        chk("rst_flags", flags, 4'b0000);
        chk("rst_id_ready", id_ready, 1'b1);
        chk("rst_ex_in1", ex_in1, 16'h0000);

        issue(3'd3, 3'd5, 1'b0, 16'h0000, 4'd0);
        step();
        id_valid = 1'b0;
        chk("f0_valid", ex_valid, 1'b1);
        chk("f0_in1", ex_in1, 16'h0000);
        chk("f0_in2", ex_in2, 16'h0000);
        step();
        chk("drain_valid", ex_valid, 1'b0);

        wb(1'b1, 3'd2, 16'h1234); step();
        wb(1'b1, 3'd4, 16'h00FF); step();
        wb(1'b0, 3'd0, 16'h0000);
        issue(3'd2, 3'd4, 1'b0, 16'h0000, 4'd1);
        step();
        chk("f1_valid", ex_valid, 1'b1);
        chk("f1_in1", ex_in1, 16'h1234);
        chk("f1_in2", ex_in2, 16'h00FF);
        chk("f1_opc", ex_opcode, 4'd1);

        issue(3'd6, 3'd6, 1'b0, 16'h0000, 4'd2);
        wb(1'b1, 3'd6, 16'hBEEF);
        step();
        wb(1'b0, 3'd0, 16'h0000);
        chk("fwd_in1", ex_in1, 16'hBEEF);
        chk("fwd_in2", ex_in2, 16'hBEEF);
        chk("fwd_opc", ex_opcode, 4'd2);

        ex_ready = 1'b0;
        issue(3'd2, 3'd0, 1'b1, 16'h0007, 4'd3);
        #1;
        chk("stall_id_ready0", id_ready, 1'b0);
        wb(1'b1, 3'd6, 16'h1111);
        for (int i = 0; i < 3; i++) begin
            step();
            wb(1'b0, 3'd0, 16'h0000);
            chk("stall_id_ready", id_ready, 1'b0);
            chk("stall_valid", ex_valid, 1'b1);
            chk("stall_in1", ex_in1, 16'hBEEF);
            chk("stall_in2", ex_in2, 16'hBEEF);
            chk("stall_opc", ex_opcode, 4'd2);
        end

        ex_ready = 1'b1;
        #1;
        chk("release_id_ready", id_ready, 1'b1);
        step();
        chk("imm_valid", ex_valid, 1'b1);
        chk("imm_in1", ex_in1, 16'h1234);
        chk("imm_in2", ex_in2, 16'h0007);
        chk("imm_opc", ex_opcode, 4'd3);

        issue(3'd6, 3'd4, 1'b0, 16'h0007, 4'd4);
        step();
        id_valid = 1'b0;
        chk("b2b_valid", ex_valid, 1'b1);
        chk("b2b_in1", ex_in1, 16'h1111);
        chk("b2b_in2", ex_in2, 16'h00FF);
        chk("b2b_opc", ex_opcode, 4'd4);
        step();
        chk("empty_valid", ex_valid, 1'b0);
        chk("empty_hold_in1", ex_in1, 16'h1111);

        flag_we = 1'b1; alu_s = 1'b1; alu_z = 1'b0; alu_c = 1'b0; alu_v = 1'b1;
        step();
        chk("flags_latch", flags, 4'b1001);
        flag_we = 1'b0; alu_s = 1'b0; alu_z = 1'b1; alu_c = 1'b1; alu_v = 1'b0;
        step();
        chk("flags_hold1", flags, 4'b1001);
        alu_s = 1'b1; alu_c = 1'b0;
        step();
        chk("flags_hold2", flags, 4'b1001);

        rst = 1'b1; flag_we = 1'b1; alu_s = 1'b1; alu_z = 1'b1; alu_c = 1'b1; alu_v = 1'b1;
        issue(3'd2, 3'd4, 1'b0, 16'h0000, 4'd5);
        wb(1'b1, 3'd3, 16'hAAAA);
        step();
        rst = 1'b0; flag_we = 1'b0; id_valid = 1'b0;
        wb(1'b0, 3'd0, 16'h0000);
        chk("rst2_flags", flags, 4'b0000);
        chk("rst2_valid", ex_valid, 1'b0);
        chk("rst2_opc", ex_opcode, 4'd0);
        issue(3'd2, 3'd3, 1'b0, 16'h0000, 4'd6);
        step();
        id_valid = 1'b0;
        chk("rst2_r2", ex_in1, 16'h0000);
        chk("rst2_r3", ex_in2, 16'h0000);

        wb(1'b1, 3'd0, 16'hFFFF); step();
        wb(1'b0, 3'd0, 16'h0000);
        issue(3'd0, 3'd4, 1'b1, 16'h0042, 4'd7);
        step();
        id_valid = 1'b0;
        chk("r0_stored", ex_in1, R0_STORED);
        chk("r0_imm", ex_in2, 16'h0042);
        issue(3'd0, 3'd0, 1'b0, 16'h0000, 4'd8);
        wb(1'b1, 3'd0, 16'h5555);
        step();
        id_valid = 1'b0;
        wb(1'b0, 3'd0, 16'h0000);
        chk("r0_fwd_in1", ex_in1, R0_FWD);
        chk("r0_fwd_in2", ex_in2, R0_FWD);

        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
